// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-subtract divider: FSM states, divide-by-zero fill, counter sizing.
package shift_sub_divider_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Every quotient bit takes this value on divide-by-zero (all ones).
  localparam logic DIV_ZERO_QBIT = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/response bundle between the control unit and the divider.
interface shift_sub_divider_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output clr, start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  clr, start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shift_sub_divider_div_step.sv
// One combinational restoring-division step: shift a dividend bit into R, subtract D if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] dx;

  always_comb begin
    sh  = {r_i, bit_i};
    dx  = (WIDTH+2)'(d_i);
    q_o = (sh >= dx);
    // R < D on entry, so the post-step value always fits in WIDTH+1 bits.
    r_o = (WIDTH+1)'(q_o ? (sh - dx) : sh);
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// SIGNED_DIV_EN: two's complement operands with sign fix-up; undefined = unsigned, same latency.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  shift_sub_divider_if.slave   div_io
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q;
  logic [WIDTH-1:0] q_q, d_q;
  logic [WIDTH:0]   r_q;
  logic             qsign_q, rsign_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   r_nx;
  logic             q_bit;
  logic             dvs_zero;

`ifdef SIGNED_DIV_EN
  assign dvd_neg = dvd_q[WIDTH-1];
  assign dvs_neg = dvs_q[WIDTH-1];
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif

  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign dvd_mag  = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_mag  = dvs_neg ? -dvs_q : dvs_q;
  assign dvs_zero = (dvs_q == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i   (r_q),
    .d_i   (d_q),
    .bit_i (q_q[WIDTH-1]),
    .r_o   (r_nx),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_io.start) state_d = LOAD;
      LOAD:    state_d = dvs_zero ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_io.clr) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (div_io.clr) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      // Status flags are registered from the next state so they line up with it.
      busy_q <= (state_d == LOAD) || (state_d == DIVIDE) || (state_d == FIX);
      done_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (div_io.start) begin
          dvd_q  <= div_io.dividend;
          dvs_q  <= div_io.divisor;
          dbz_q  <= 1'b0;
          quot_q <= '0;
          rem_q  <= '0;
        end
        LOAD: begin
          q_q     <= dvd_mag;
          d_q     <= dvs_mag;
          r_q     <= '0;
          qsign_q <= dvd_neg ^ dvs_neg;
          rsign_q <= dvd_neg;
          cnt_q   <= '0;
          if (dvs_zero) begin
            quot_q <= {WIDTH{DIV_ZERO_QBIT}};
            rem_q  <= dvd_q;
            dbz_q  <= 1'b1;
          end
        end
        DIVIDE: begin
          r_q   <= r_nx;
          q_q   <= {q_q[WIDTH-2:0], q_bit};
          cnt_q <= (cnt_q == LAST_STEP) ? '0 : cnt_q + CW'(1);
        end
        FIX: begin
          quot_q <= qsign_q ? -q_q : q_q;
          rem_q  <= rsign_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign div_io.busy        = busy_q;
  assign div_io.done        = done_q;
  assign div_io.quotient    = quot_q;
  assign div_io.remainder   = rem_q;
  assign div_io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (WIDTH=8); signed vectors selected by SIGNED_DIV_EN.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  shift_sub_divider_if #(.WIDTH(W)) dif ();

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_io (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(dif.busy), 0);
    chk({tag, "_done"}, 32'(dif.done), 0);
    chk({tag, "_q"},    32'(dif.quotient), 0);
    chk({tag, "_r"},    32'(dif.remainder), 0);
    chk({tag, "_dz"},   32'(dif.div_by_zero), 0);
  endtask

  // Start pulse sampled at the next rising edge (edge 0); operands scrambled afterwards.
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
    @(posedge clk);
    #1 dif.start = 1'b0; dif.dividend = ~a; dif.divisor = ~b;
  endtask

  // Returns the cycle done is seen in (-1 on timeout); optional extra start pulse in cycle pulse_at.
  task automatic wait_done(input int pulse_at, output int lat, output int busy_n);
    lat = -1; busy_n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (dif.done) begin
        lat = c;
        chk("busy_in_done", 32'(dif.busy), 0);
        break;
      end
      busy_n += int'(dif.busy);
      if (c == pulse_at) begin
        dif.start = 1'b1; dif.dividend = 8'h11; dif.divisor = 8'h02;
      end else dif.start = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int bn,
                              input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic edz, input int elat);
    chk({tag, "_lat"},  32'(lat), 32'(elat));
    chk({tag, "_busy"}, 32'(bn), 32'(elat - 1));
    chk({tag, "_q"},    32'(dif.quotient), 32'(eq));
    chk({tag, "_r"},    32'(dif.remainder), 32'(er));
    chk({tag, "_dz"},   32'(dif.div_by_zero), 32'(edz));
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int elat, input int pulse_at);
    int lat, bn;
    go(a, b);
    wait_done(pulse_at, lat, bn);
    check_result(tag, lat, bn, eq, er, edz, elat);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(dif.done), 0);
    chk({tag, "_hold"},  32'(dif.quotient), 32'(eq));
  endtask

  task automatic abort_then_fresh(input bit use_clr);
    int dn;
    go(8'd200, 8'd7);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    @(negedge clk);
    if (use_clr) begin
      dif.clr = 1'b1;
      @(posedge clk);
      #1 chk_idle_zero("clr_abort");
      @(negedge clk);
      dif.clr = 1'b0;
    end else begin
      rst = 1'b1;
      #1 chk_idle_zero("rst_abort");
      @(negedge clk);
      rst = 1'b0;
    end
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      dn += int'(dif.done);
    end
    chk(use_clr ? "clr_no_done" : "rst_no_done", 32'(dn), 0);
    chk(use_clr ? "clr_idle_q" : "rst_idle_q", 32'(dif.quotient), 0);
    run(use_clr ? "clr_15_4" : "rst_15_4", 8'd15, 8'd4, 8'h03, 8'h03, 1'b0, 11, 0);
  endtask

  initial begin
    int lat, bn;
    dif.clr = 1'b0; dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    #1 chk_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run("u200_7", 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 11, 0);
    run("dz_2d",  8'h2D,  8'h00, 8'hFF, 8'h2D, 1'b1, 2, 0);
    run("after_dz_9_3", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 11, 0);
`ifdef SIGNED_DIV_EN
    run("s_9c_07", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 11, 0);
    run("s_64_f9", 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 11, 0);
    run("s_ovf",   8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 11, 0);
`else
    run("u_9c_07", 8'h9C, 8'h07, 8'h16, 8'h02, 1'b0, 11, 0);
    run("u_64_f9", 8'h64, 8'hF9, 8'h00, 8'h64, 1'b0, 11, 0);
    run("u_80_ff", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 11, 0);
`endif
    run("ff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 11, 0);
    run("ignore_mid", 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 11, 4);

    // Start during DONE is dropped; the same request held into IDLE is taken.
    go(8'd9, 8'd3);
    wait_done(0, lat, bn);
    check_result("b2b_first", lat, bn, 8'h03, 8'h00, 1'b0, 11);
    dif.start = 1'b1; dif.dividend = 8'h50; dif.divisor = 8'h05;
    @(negedge clk);
    chk("b2b_ignored_busy", 32'(dif.busy), 0);
    chk("b2b_ignored_done", 32'(dif.done), 0);
    @(posedge clk);
    #1 dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    wait_done(0, lat, bn);
    check_result("b2b_second", lat, bn, 8'h10, 8'h00, 1'b0, 11);

    abort_then_fresh(1'b0);
    abort_then_fresh(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
